// File: rtl/quant_cmd_driver.sv
// Requantization CFU initiator: loads six quant params, streams int32 accumulators through
// cmd 7 and packs the returned int8 results four per 32-bit output word.
module quant_cmd_driver #(
  parameter int unsigned INT32_SIZE    = 32,
  parameter int unsigned QUANT_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [INT32_SIZE-1:0] cfg_bias,
  input  logic [INT32_SIZE-1:0] cfg_mult,
  input  logic [INT32_SIZE-1:0] cfg_shift,
  input  logic [INT32_SIZE-1:0] cfg_act_min,
  input  logic [INT32_SIZE-1:0] cfg_act_max,
  input  logic [INT32_SIZE-1:0] cfg_out_offset,
  output logic                  busy,
  output logic                  done,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [INT32_SIZE-1:0] acc_data,
  input  logic                  acc_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [2:0]            out_bytes,
  output logic                  out_last,
  output logic [6:0]            q_cmd,
  output logic [INT32_SIZE-1:0] q_inp0,
  output logic [INT32_SIZE-1:0] q_inp1,
  input  logic [INT32_SIZE-1:0] q_ret
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [2:0]            r_load_idx;
  logic [INT32_SIZE-1:0] r_param [6];
  logic [6:0]            r_q_cmd;
  logic [INT32_SIZE-1:0] r_q_inp1;
  logic [QUANT_LATENCY:0] r_pipe_v;
  logic [QUANT_LATENCY:0] r_pipe_l;

  logic [8:0]            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [31:0]           r_out_data;
  logic [2:0]            r_out_bytes;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic                  w_acc_hs;
  logic                  w_out_hs;
  logic                  w_push;
  logic                  w_pop;
  logic [8:0]            w_pop_entry;
  logic [31:0]           w_inflight;
  logic [31:0]           w_pk_data;
  logic [2:0]            w_pk_bytes;
  logic                  w_pk_valid;
  logic                  w_pk_last;
  logic                  w_unused;

  // Credit counts results still travelling through the responder, so the FIFO can never overflow
  always_comb begin
    w_inflight = '0;
    for (int unsigned k = 0; k <= QUANT_LATENCY; k++) begin
      w_inflight = w_inflight + 32'(r_pipe_v[k]);
    end
  end

  assign acc_ready   = (r_state == ST_STREAM) && ((32'(r_count) + w_inflight) < FIFO_DEPTH);
  assign w_acc_hs    = acc_valid && acc_ready;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_push      = r_pipe_v[QUANT_LATENCY];
  assign w_pop       = (r_count != '0) && (!r_out_valid || out_ready);
  assign w_pop_entry = r_fifo[r_rptr];
  assign w_unused    = ^q_ret[INT32_SIZE-1:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load_idx <= '0;
      r_q_cmd    <= '0;
      r_q_inp1   <= '0;
      r_pipe_v   <= '0;
      r_pipe_l   <= '0;
    end else begin
      r_done   <= 1'b0;
      r_q_cmd  <= '0;
      r_q_inp1 <= '0;
      r_pipe_v <= {r_pipe_v[QUANT_LATENCY-1:0], w_acc_hs};
      r_pipe_l <= {r_pipe_l[QUANT_LATENCY-1:0], w_acc_hs && acc_last};
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_load_idx <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_q_cmd    <= 7'(r_load_idx) + 7'd1;
          r_q_inp1   <= r_param[r_load_idx];
          r_load_idx <= r_load_idx + 3'd1;
          if (r_load_idx == 3'd5) r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_acc_hs) begin
            r_q_cmd  <= 7'd7;
            r_q_inp1 <= acc_data;
            if (acc_last) r_state <= ST_DRAIN;
          end
        end
        default: begin
          if (w_out_hs && r_out_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Parameters persist across reset, matching the responder which keeps them too
  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_IDLE && start) begin
      r_param[0] <= cfg_bias;
      r_param[1] <= cfg_mult;
      r_param[2] <= cfg_shift;
      r_param[3] <= cfg_act_min;
      r_param[4] <= cfg_act_max;
      r_param[5] <= cfg_out_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {r_pipe_l[QUANT_LATENCY], q_ret[7:0]};
  end

  // A pop may land in lane 0 in the same cycle the held word is handshaken
  always_comb begin
    w_pk_data  = r_out_data;
    w_pk_bytes = r_out_bytes;
    w_pk_valid = r_out_valid;
    w_pk_last  = r_out_last;
    if (w_out_hs) begin
      w_pk_data  = '0;
      w_pk_bytes = '0;
      w_pk_valid = 1'b0;
      w_pk_last  = 1'b0;
    end
    if (w_pop) begin
      w_pk_data[{w_pk_bytes[1:0], 3'b000} +: 8] = w_pop_entry[7:0];
      w_pk_bytes = w_pk_bytes + 3'd1;
      if (w_pk_bytes == 3'd4 || w_pop_entry[8]) begin
        w_pk_valid = 1'b1;
        w_pk_last  = w_pop_entry[8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_out_data  <= w_pk_data;
      r_out_bytes <= w_pk_bytes;
      r_out_valid <= w_pk_valid;
      r_out_last  <= w_pk_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(w_push && !w_pop && r_count == CNT_W'(FIFO_DEPTH)));
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;
  assign out_last  = r_out_last;
  assign q_cmd     = r_q_cmd;
  assign q_inp0    = '0;
  assign q_inp1    = r_q_inp1;

endmodule

// File: tb/tb_quant_cmd_driver.sv
// Scoreboard bench for quant_cmd_driver: latency-1 instance for the main jobs, a latency-3
// instance for the single-byte job; responders echo the low byte of cmd-7 operands.
module tb_quant_cmd_driver;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [31:0] cfg_bias, cfg_mult, cfg_shift, cfg_act_min, cfg_act_max, cfg_out_offset;
  logic        busy, done, acc_valid, acc_ready, acc_last;
  logic [31:0] acc_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic [6:0]  q_cmd;
  logic [31:0] q_inp0, q_inp1, q_ret;

  logic        start_3, busy_3, done_3, acc_valid_3, acc_ready_3, acc_last_3;
  logic [31:0] acc_data_3;
  logic        out_valid_3, out_last_3;
  logic [31:0] out_data_3;
  logic [2:0]  out_bytes_3;
  logic [6:0]  q_cmd_3;
  logic [31:0] q_inp0_3, q_inp1_3, q_ret_3, r3_a, r3_b;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_hs_cyc = -10;
  word_t sb[$];

  quant_cmd_driver #(.INT32_SIZE(32), .QUANT_LATENCY(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max), .cfg_out_offset(cfg_out_offset),
    .busy(busy), .done(done), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_last(acc_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
    .q_cmd(q_cmd), .q_inp0(q_inp0), .q_inp1(q_inp1), .q_ret(q_ret)
  );

  quant_cmd_driver #(.INT32_SIZE(32), .QUANT_LATENCY(3), .FIFO_DEPTH(8)) dut3 (
    .clk(clk), .reset(reset), .start(start_3),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max), .cfg_out_offset(cfg_out_offset),
    .busy(busy_3), .done(done_3), .acc_valid(acc_valid_3), .acc_ready(acc_ready_3),
    .acc_data(acc_data_3), .acc_last(acc_last_3), .out_valid(out_valid_3),
    .out_ready(1'b1), .out_data(out_data_3), .out_bytes(out_bytes_3), .out_last(out_last_3),
    .q_cmd(q_cmd_3), .q_inp0(q_inp0_3), .q_inp1(q_inp1_3), .q_ret(q_ret_3)
  );

  // Responders: one registered stage, and three stages for the latency-3 instance
  always @(posedge clk) begin
    q_ret <= (q_cmd == 7'd7) ? {24'hA5A5A5, q_inp1[7:0]} : 32'hDEADBEEF;
    r3_a  <= (q_cmd_3 == 7'd7) ? {24'hA5A5A5, q_inp1_3[7:0]} : 32'hDEADBEEF;
    r3_b  <= r3_a;
    q_ret_3 <= r3_b;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout required event", name);
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: actual %h required none", out_data);
      end else begin
        word_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_bytes", 32'(out_bytes), 32'(e.bytes));
        check("out_last", 32'(out_last), 32'(e.last));
      end
      if (out_last) last_hs_cyc = cyc;
    end
    if (done) begin
      check("done_one_cycle_after_last", cyc, last_hs_cyc + 1);
      check("busy_low_at_done", 32'(busy), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_acc_ready"}, 32'(acc_ready), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_bytes"}, 32'(out_bytes), 0);
    check({tag, "_q_cmd"}, 32'(q_cmd), 0);
    check({tag, "_q_inp1"}, q_inp1, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_accs(input logic [7:0] base, input int n, input bit set_last);
    for (int i = 0; i < n; i++) begin
      int w;
      acc_valid = 1'b1;
      acc_data  = 32'hCAFE0000 | 32'(base + 8'(i));
      acc_last  = set_last && (i == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!acc_ready && w < 300);
      if (!acc_ready) begin
        fail_now("acc_accept");
        break;
      end
      @(posedge clk); #1;
    end
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!done && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!done) fail_now("done_pulse");
  endtask

  task automatic check_load();
    logic [31:0] exp_p [6];
    int w = 0;
    exp_p[0] = 32'd5;
    exp_p[1] = 32'h40000000;
    exp_p[2] = 32'hFFFFFFFF;
    exp_p[3] = 32'hFFFFFF80;
    exp_p[4] = 32'd127;
    exp_p[5] = 32'd3;
    do begin
      @(negedge clk);
      w++;
    end while (q_cmd !== 7'd1 && w < 12);
    if (q_cmd !== 7'd1) begin
      fail_now("load_cmd1");
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (k > 0) @(negedge clk);
        check("load_cmd", 32'(q_cmd), 32'(k + 1));
        check("load_inp1", q_inp1, exp_p[k]);
        check("load_inp0", q_inp0, 0);
      end
      @(negedge clk);
      check("first_cmd7", 32'(q_cmd), 32'd7);
      check("first_cmd7_inp1", q_inp1, 32'hCAFE0001);
    end
  endtask

  initial begin
    int stall_acc, w, n7, c7, cv;
    bit saw_low, seen_done3;
    reset = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0; acc_last = 1'b0;
    out_ready = 1'b1;
    start_3 = 1'b0; acc_valid_3 = 1'b0; acc_data_3 = '0; acc_last_3 = 1'b0;
    cfg_bias = 32'd5; cfg_mult = 32'h40000000; cfg_shift = 32'hFFFFFFFF;
    cfg_act_min = 32'hFFFFFF80; cfg_act_max = 32'd127; cfg_out_offset = 32'd3;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk); #1 reset = 1'b0;

    // Eight results, two full words
    sb.push_back('{32'h04030201, 3'd4, 1'b0});
    sb.push_back('{32'h08070605, 3'd4, 1'b1});
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    fork
      check_load();
      send_accs(8'h01, 8, 1'b1);
    join
    wait_done();

    // Five results, partial last word
    sb.push_back('{32'h14131211, 3'd4, 1'b0});
    sb.push_back('{32'h00000015, 3'd1, 1'b1});
    pulse_start();
    send_accs(8'h11, 5, 1'b1);
    wait_done();

    // Output stalled while twenty accumulators are offered
    sb.push_back('{32'h24232221, 3'd4, 1'b0});
    sb.push_back('{32'h28272625, 3'd4, 1'b0});
    sb.push_back('{32'h2C2B2A29, 3'd4, 1'b0});
    sb.push_back('{32'h302F2E2D, 3'd4, 1'b0});
    sb.push_back('{32'h34333231, 3'd4, 1'b1});
    out_ready = 1'b0;
    stall_acc = 0;
    saw_low = 1'b0;
    pulse_start();
    fork
      send_accs(8'h21, 20, 1'b1);
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (acc_valid && out_valid && !out_ready) begin
            if (acc_ready) stall_acc++;
            else saw_low = 1'b1;
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    check("acc_ready_dropped", 32'(saw_low), 32'd1);
    check("stall_accepts_within_depth", 32'(stall_acc <= 8), 32'd1);
    wait_done();

    // Reset with results in flight; the aborted job must leave nothing behind
    out_ready = 1'b0;
    pulse_start();
    send_accs(8'h50, 6, 1'b0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    sb.push_back('{32'h00636261, 3'd3, 1'b1});
    pulse_start();
    send_accs(8'h61, 3, 1'b1);
    wait_done();

    // Latency-3 instance, single accumulator that is also last
    @(posedge clk); #1 start_3 = 1'b1;
    acc_valid_3 = 1'b1; acc_data_3 = 32'hCAFE007A; acc_last_3 = 1'b1;
    @(posedge clk); #1 start_3 = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!acc_ready_3 && w < 30);
    if (!acc_ready_3) fail_now("l3_acc_accept");
    @(posedge clk); #1 acc_valid_3 = 1'b0; acc_last_3 = 1'b0;
    n7 = 0; c7 = -1; cv = -1; seen_done3 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (q_cmd_3 == 7'd7) begin
        n7++;
        if (c7 < 0) c7 = c;
      end
      if (out_valid_3 && cv < 0) begin
        cv = c;
        check("l3_out_data", out_data_3, 32'h0000007A);
        check("l3_out_bytes", 32'(out_bytes_3), 32'd1);
        check("l3_out_last", 32'(out_last_3), 32'd1);
      end
      if (done_3) seen_done3 = 1'b1;
    end
    check("l3_cmd7_count", n7, 1);
    check("l3_latency_ge3", 32'(c7 >= 0 && cv >= 0 && (cv - c7) >= 3), 32'd1);
    check("l3_done", 32'(seen_done3), 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
